// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide unit with HI/LO funct decode.
// Holds the HI/LO architectural registers and runs MULT/MULTU/DIV/DIVU
// over a fixed latency using a down-counter with terminal-count compare.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | accepts mult/div starts and MTHI/MTLO writes
//   RUN   | operation in flight; counter decrements; HI/LO written at tc
module mdu_ctrl #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rdata
);

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             is_div_q, is_div_d;
  logic             is_sgn_q, is_sgn_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;

  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic               a_neg, b_neg, b_zero;
  logic [WIDTH-1:0]   a_mag, b_mag, b_div, q_mag, r_mag, quot, rem;

  // Arithmetic on the latched operands; only sampled at terminal count.
  // Signed divide works on magnitudes then restores signs, which also yields
  // most-negative / -1 = most-negative with zero remainder.
  always_comb begin
    a_ext  = is_sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    b_ext  = is_sgn_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod   = a_ext * b_ext;
    a_neg  = is_sgn_q & a_q[WIDTH-1];
    b_neg  = is_sgn_q & b_q[WIDTH-1];
    a_mag  = a_neg ? -a_q : a_q;
    b_mag  = b_neg ? -b_q : b_q;
    b_zero = (b_q == '0);
    b_div  = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    q_mag  = a_mag / b_div;
    r_mag  = a_mag % b_div;
    quot   = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem    = a_neg ? -r_mag : r_mag;
  end

  // Next-state: decode in IDLE, count down and retire in RUN.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    is_div_d = is_div_q;
    is_sgn_d = is_sgn_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (funct)
            F_MULT, F_MULTU, F_DIV, F_DIVU: begin
              state_d  = RUN;
              a_d      = a;
              b_d      = b;
              is_div_d = funct[1];
              is_sgn_d = ~funct[0];
              cnt_d    = funct[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
            end
            F_MTHI:  hi_d = a;
            F_MTLO:  lo_d = a;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (!is_div_q) begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end else if (!b_zero) begin
            hi_d = rem;
            lo_d = quot;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, operand latches and HI/LO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
      is_sgn_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      is_div_q <= is_div_d;
      is_sgn_q <= is_sgn_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  // MFHI/MFLO read port; returns current registers even while busy.
  always_comb begin
    rdata = '0;
    if (funct == F_MFHI)      rdata = hi_q;
    else if (funct == F_MFLO) rdata = lo_q;
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl with default parameters (32-bit, 5/10 cycles).
module tb_mdu_ctrl;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic        clk, rst_n, start;
  logic [5:0]  funct;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo, rdata;

  int n_pass  = 0;
  int n_total = 0;

  mdu_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .funct (funct),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo),
    .rdata (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Issue one mult/div, scramble operands afterwards, count busy/done cycles.
  task automatic run_op(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv,
                        output int nb, output int nd);
    @(negedge clk);
    start = 1'b1; funct = f; a = av; b = bv;
    nb = 0; nd = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      start = 1'b0; funct = 6'd0; a = ~av; b = ~bv;
      if (busy) nb++;
      if (done) nd++;
    end
  endtask

  task automatic mt(input logic [5:0] f, input logic [31:0] v);
    @(negedge clk);
    start = 1'b1; funct = f; a = v;
    @(negedge clk);
    start = 1'b0; funct = 6'd0; a = 32'd0;
  endtask

  initial begin
    int  nb, nd;
    bit  chk_next;

    rst_n = 1'b0; start = 1'b0; funct = 6'd0; a = 32'd0; b = 32'd0;
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi",   64'(hi),   64'd0);
    chk("rst_lo",   64'(lo),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    mt(F_MTHI, 32'h55);
    mt(F_MTLO, 32'h66);
    chk("mthi", 64'(hi), 64'h55);
    chk("mtlo", 64'(lo), 64'h66);

    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_hi",   64'(hi),   64'd0);
    chk("async_rst_lo",   64'(lo),   64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(F_MULT, 32'hFFFF_FFFE, 32'd3, nb, nd);
    chk("mult_busy", 64'(nb), 64'd5);
    chk("mult_done", 64'(nd), 64'd1);
    chk("mult_hi",   64'(hi), 64'hFFFF_FFFF);
    chk("mult_lo",   64'(lo), 64'hFFFF_FFFA);

    run_op(F_MULTU, 32'hFFFF_FFFE, 32'd3, nb, nd);
    chk("multu_busy", 64'(nb), 64'd5);
    chk("multu_hi",   64'(hi), 64'h2);
    chk("multu_lo",   64'(lo), 64'hFFFF_FFFA);

    run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, nb, nd);
    chk("div_busy", 64'(nb), 64'd10);
    chk("div_done", 64'(nd), 64'd1);
    chk("div_lo",   64'(lo), 64'hFFFF_FFFD);
    chk("div_hi",   64'(hi), 64'hFFFF_FFFF);

    run_op(F_DIVU, 32'd7, 32'd2, nb, nd);
    chk("divu_lo", 64'(lo), 64'd3);
    chk("divu_hi", 64'(hi), 64'd1);

    run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, nb, nd);
    chk("div_ovf_lo", 64'(lo), 64'h8000_0000);
    chk("div_ovf_hi", 64'(hi), 64'd0);

    mt(F_MTHI, 32'h11);
    mt(F_MTLO, 32'h22);
    run_op(F_DIVU, 32'd5, 32'd0, nb, nd);
    chk("div0_busy", 64'(nb), 64'd10);
    chk("div0_done", 64'(nd), 64'd1);
    chk("div0_hi",   64'(hi), 64'h11);
    chk("div0_lo",   64'(lo), 64'h22);

    @(negedge clk);
    funct = F_MFHI; #1 chk("mfhi_rdata", 64'(rdata), 64'h11);
    funct = F_MFLO; #1 chk("mflo_rdata", 64'(rdata), 64'h22);
    funct = F_MULT; #1 chk("other_rdata", 64'(rdata), 64'd0);
    funct = 6'd0;

    // Starts issued during RUN must be ignored.
    @(negedge clk);
    start = 1'b1; funct = F_MULT; a = 32'd6; b = 32'd7;
    nb = 0; nd = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) nd++;
      if (i < 3) begin
        start = 1'b1;
        funct = (i == 0) ? F_MTLO : F_DIV;
        a     = (i == 0) ? 32'hDEAD : 32'd100;
        b     = 32'd3;
      end else begin
        start = 1'b0; funct = F_MFLO; a = 32'd0; b = 32'd0;
        if (i == 3) begin
          #1 chk("stale_rdata_run", 64'(rdata), 64'h22);
        end
      end
    end
    funct = 6'd0;
    chk("ign_busy", 64'(nb), 64'd5);
    chk("ign_done", 64'(nd), 64'd1);
    chk("ign_lo",   64'(lo), 64'd42);
    chk("ign_hi",   64'(hi), 64'd0);

    // Back-to-back: new MULT issued in the done cycle.
    @(negedge clk);
    start = 1'b1; funct = F_MULT; a = 32'd3; b = 32'd4;
    nb = 0; nd = 0; chk_next = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      start = 1'b0; funct = 6'd0;
      if (chk_next) begin
        chk("b2b_busy_rise", 64'(busy), 64'd1);
        chk_next = 1'b0;
      end
      if (busy) nb++;
      if (done) begin
        nd++;
        if (nd == 1) begin
          chk("b2b_first_lo", 64'(lo), 64'd12);
          start = 1'b1; funct = F_MULT; a = 32'd5; b = 32'd5;
          chk_next = 1'b1;
        end
      end
    end
    chk("b2b_busy", 64'(nb), 64'd10);
    chk("b2b_done", 64'(nd), 64'd2);
    chk("b2b_lo",   64'(lo), 64'd25);

    // Reset in the middle of a divide.
    @(negedge clk);
    start = 1'b1; funct = F_DIV; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0; funct = 6'd0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_hi",   64'(hi),   64'd0);
    chk("midrst_lo",   64'(lo),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nb = 0; nd = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) nd++;
    end
    chk("midrst_no_done", 64'(nd), 64'd0);
    chk("midrst_no_busy", 64'(nb), 64'd0);
    funct = F_MFLO;
    #1 chk("midrst_mflo", 64'(rdata), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
